// File: rtl/wb_interconnect.sv
`default_nettype none
// ============================================================================
// Module      : wb_interconnect
// Description : Single-master, NSLAVES-slave classic Wishbone address decoder
//               with registered request broadcast and stall timeout.
// Revision    : 1.0
// ============================================================================
module wb_interconnect #(
    parameter int                              NSLAVES    = 2,
    parameter int                              ADDR_WIDTH = 32,
    parameter logic [NSLAVES*ADDR_WIDTH-1:0]   BASE       = {32'h8000_0000, 32'h4000_0000},
    parameter logic [NSLAVES*ADDR_WIDTH-1:0]   MASK       = {32'hFFF0_0000, 32'hFFFF_FFC0},
    parameter int                              TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm__adr,
    input  logic [31:0]             wbm__dat_w,
    input  logic [3:0]              wbm__sel,
    input  logic                    wbm__we,
    input  logic                    wbm__cyc,
    input  logic                    wbm__stb,
    output logic [31:0]             wbm__dat_r,
    output logic                    wbm__ack,
    output logic                    wbm__err,

    output logic [ADDR_WIDTH-1:0]   wbs__adr,
    output logic [31:0]             wbs__dat_w,
    output logic [3:0]              wbs__sel,
    output logic                    wbs__we,
    output logic [NSLAVES-1:0]      wbs__cyc,
    output logic [NSLAVES-1:0]      wbs__stb,
    input  logic [NSLAVES*32-1:0]   wbs__dat_r,
    input  logic [NSLAVES-1:0]      wbs__ack,
    input  logic [NSLAVES-1:0]      wbs__err
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NSLAVES-1:0]      strb_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [31:0]             dat_w_q;
    logic [3:0]              sel_q;
    logic                    we_q;
    logic [31:0]             dat_r_q;
    logic                    ack_q;
    logic                    err_q;

    logic [NSLAVES-1:0]      w_hit;
    logic [NSLAVES-1:0]      w_onehot;
    logic                    w_found;
    logic                    w_sel_ack;
    logic                    w_sel_err;
    logic [31:0]             w_sel_dat;

    generate
        for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_match
            assign w_hit[gi] =
                ((wbm__adr & MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 (BASE[gi*ADDR_WIDTH +: ADDR_WIDTH] & MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]));
        end
    endgenerate

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        w_onehot = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (w_hit[i] && !w_found) begin
                w_onehot[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    // The live strobe vector doubles as the slave select while BUSY.
    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (strb_q[i]) begin
                w_sel_dat = w_sel_dat | wbs__dat_r[i*32 +: 32];
            end
        end
    end

    assign w_sel_ack = |(wbs__ack & strb_q);
    assign w_sel_err = |(wbs__err & strb_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            strb_q  <= '0;
            adr_q   <= '0;
            dat_w_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            dat_r_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (wbm__cyc && wbm__stb) begin
                        if (w_found) begin
                            adr_q   <= wbm__adr;
                            dat_w_q <= wbm__dat_w;
                            sel_q   <= wbm__sel;
                            we_q    <= wbm__we;
                            strb_q  <= w_onehot;
                            cnt_q   <= '0;
                            state_q <= S_BUSY;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_BUSY: begin
                    if (!wbm__cyc) begin
                        strb_q  <= '0;
                        state_q <= S_IDLE;
                    end else if (w_sel_err) begin
                        strb_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else if (w_sel_ack) begin
                        strb_q  <= '0;
                        dat_r_q <= w_sel_dat;
                        ack_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else if (cnt_q == C_TIMEOUT) begin
                        strb_q  <= '0;
                        err_q   <= 1'b1;
                        state_q <= S_ERR;
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                    end
                end
                S_RESP: begin
                    ack_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    strb_q  <= '0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbm__dat_r = dat_r_q;
    assign wbm__ack   = ack_q;
    assign wbm__err   = err_q;
    assign wbs__adr   = adr_q;
    assign wbs__dat_w = dat_w_q;
    assign wbs__sel   = sel_q;
    assign wbs__we    = we_q;
    assign wbs__cyc   = strb_q;
    assign wbs__stb   = strb_q;

endmodule
`default_nettype wire

// File: doc/wb_interconnect.md
WB_INTERCONNECT -- requirements
Module: wb_interconnect

Interface
REQ-001 The block SHALL have parameter NSLAVES, default 2, meaning the number of slave ports (legal range 1..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the master address width.
REQ-003 The block SHALL have parameter BASE, default {32'h8000_0000, 32'h4000_0000}, meaning the packed per-slave base addresses, with slave 0 in the low word.
REQ-004 The block SHALL have parameter MASK, default {32'hFFF0_0000, 32'hFFFF_FFC0}, meaning the packed per-slave decode masks.
REQ-005 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles a slave may stall before an error is returned (legal range 1..65535).
REQ-006 Port clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, asynchronous assert, active-low (0 = reset).
REQ-008 Ports wbm__adr (ADDR_WIDTH), wbm__dat_w (32), wbm__sel (4), wbm__we (1), wbm__cyc (1), wbm__stb (1) SHALL be inputs forming the classic Wishbone master request.
REQ-009 Ports wbm__dat_r (32), wbm__ack (1), wbm__err (1) SHALL be outputs forming the master response.
REQ-010 Ports wbs__adr (ADDR_WIDTH), wbs__dat_w (32), wbs__sel (4), wbs__we (1) SHALL be outputs, registered copies of the request broadcast to all slaves.
REQ-011 Ports wbs__cyc and wbs__stb, outputs, NSLAVES bits each, SHALL carry one-hot per-slave strobes.
REQ-012 Port wbs__dat_r, input, NSLAVES*32 bits, SHALL carry packed slave read data.
REQ-013 Ports wbs__ack and wbs__err, inputs, NSLAVES bits each, SHALL carry per-slave responses.

Function
REQ-014 The block SHALL implement FSM states IDLE, BUSY, RESP and ERR.
REQ-015 Slave i SHALL match when (wbm__adr & MASK[i]) == (BASE[i] & MASK[i]); if several slaves match, the lowest index SHALL win.
REQ-016 In IDLE with wbm__cyc & wbm__stb and a match, the block SHALL register the address, data, sel, we and one-hot select, and go to BUSY.
REQ-017 In IDLE with wbm__cyc & wbm__stb and no match, the block SHALL go to ERR without asserting any wbs__cyc.
REQ-018 In BUSY, wbs__cyc[sel] and wbs__stb[sel] SHALL be 1 and all other bits 0.
REQ-019 In BUSY, an ack/err from non-selected slaves SHALL be ignored.
REQ-020 In BUSY, if wbs__err[sel] is high, the block SHALL go to ERR; this SHALL take priority over a simultaneous wbs__ack[sel].
REQ-021 In BUSY, if wbs__ack[sel] is high, the block SHALL capture wbs__dat_r[sel] into wbm__dat_r and go to RESP.
REQ-022 Slave strobes SHALL drop in the cycle after the response is sampled.
REQ-023 In BUSY, a timeout counter ($clog2(TIMEOUT+1) bits, cleared on entry to BUSY) SHALL increment each cycle without a response.
REQ-024 When the timeout counter equals TIMEOUT, the block SHALL go to ERR and drop the slave strobes; a late slave ack SHALL be ignored.
REQ-025 In RESP, wbm__ack SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-026 In ERR, wbm__err SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-027 wbm__ack and wbm__err SHALL never be high together.
REQ-028 Latency: request sampled at cycle 0, slave strobe at cycle 1, slave ack at cycle k, master ack at cycle k+1; an unmapped address SHALL produce wbm__err at cycle 1.
REQ-029 If wbm__cyc falls while in BUSY, the block SHALL abort to IDLE next cycle with strobes low and no master response.
REQ-030 New requests SHALL be accepted only in IDLE, so at most one transaction is outstanding.
REQ-031 wbm__dat_r SHALL hold its last captured value until the next ack; it SHALL be unchanged on errors.

Reset
REQ-032 When rst = 0, asynchronously: FSM = IDLE; counter = 0; wbm__ack = wbm__err = 0; wbm__dat_r = 0; wbs__cyc = wbs__stb = 0; wbs__adr/dat_w/sel/we = 0.
REQ-033 Reset asserted mid-transaction SHALL drop all strobes immediately, and no response SHALL be issued after release.
REQ-034 Release SHALL be synchronised by the user; the block SHALL accept requests from the first clock after rst = 1.

Verification
REQ-035 Read 0x8000_0010, slave1 acks after 3 cycles with 0xDEAD_BEEF -> wbs__stb = 2'b10 at cycle 1, wbm__ack at cycle 5, wbm__dat_r = 0xDEAD_BEEF.
REQ-036 Write 0x4000_0004, data 0x1234_5678, sel 4'b0011 -> wbs__stb = 2'b01, wbs__dat_w/sel match, single wbm__ack pulse.
REQ-037 Access to unmapped 0x0000_1000 -> wbm__err at cycle 1, wbs__cyc stays 2'b00 throughout.
REQ-038 TIMEOUT = 16, slave never acks -> wbm__err exactly 17 cycles after strobe assertion, strobe low next cycle, a later slave ack ignored.
REQ-039 Slave asserts ack and err in the same cycle -> wbm__err only, wbm__dat_r unchanged.
REQ-040 rst pulled low in BUSY, then master cyc drop -> strobes 0 without a clock edge, no ack/err after release, next request served normally.
